// File: rtl/fpu_lane_cluster_pkg.sv
// Shared types for the FPU lane cluster: core-wide constants (len5_pkg) and
// execution-pipe result record (expipe_pkg).
package len5_pkg;
    localparam int FLEN        = 64;
    localparam int ROB_IDX_LEN = 4;
    typedef logic [ROB_IDX_LEN-1:0] rob_idx_t;
    typedef logic [4:0]             except_code_t;

    localparam logic [2:0]   FPU_RM_DYN            = 3'b111;
    localparam except_code_t E_ILLEGAL_INSTRUCTION = 5'd2;
endpackage

package expipe_pkg;
    import len5_pkg::*;

    typedef struct packed {
        rob_idx_t        rob_idx;
        logic [FLEN-1:0] result;
        logic            except_raised;
        except_code_t    except_code;
        logic [4:0]      fflags;
    } fpu_res_t;

    // Resolved rounding modes 101, 110 and 111 are reserved
    function automatic logic rm_is_illegal(input logic [2:0] rm);
        return (rm == 3'b101) || (rm == 3'b110) || (rm == 3'b111);
    endfunction
endpackage

// File: rtl/fpu_lane_cluster_chk.sv
// Checker: a lane must never return a result while it has nothing in flight.
module fpu_lane_cluster_chk #(
    parameter int N = 2
) (
    input logic         clk_i,
    input logic         rst_i,
    input logic [N-1:0] cap_i,
    input logic [N-1:0] idle_i
);
    // Flag any capture on a lane whose in-flight count is zero
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert ((cap_i & idle_i) == '0)
                else $error("fpu_lane_cluster: result captured on idle lane %b", cap_i & idle_i);
        end
    end
endmodule

// File: rtl/fpu_rr_picker.sv
// Round-robin picker: first requester at or after the pointer, wrapping.
module fpu_rr_picker #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    // Scan N positions starting at the pointer; the first hit wins
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any_o && req_i[(int'(ptr_i) + k) % N]) begin
                any_o = 1'b1;
                gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
                idx_o = IW'((int'(ptr_i) + k) % N);
            end else begin
                any_o = any_o;
            end
        end
    end
endmodule

// File: rtl/fpu_lane_cluster.sv
// FPU lane cluster: resolves rm, dispatches round-robin to NUM_LANES lanes,
// buffers lane results and returns them one per cycle tagged by ROB index.
// Optional feature macro: FPU_RM_CHECK_EN (illegal-rm detection + bypass slot).
module fpu_lane_cluster
    import len5_pkg::*;
    import expipe_pkg::*;
#(
    parameter int NUM_LANES    = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int EU_CTL_LEN   = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                flush_i,
    input  logic                                rs_valid_i,
    output logic                                rs_ready_o,
    input  logic [EU_CTL_LEN-1:0]               rs_ctl_i,
    input  logic [2:0]                          rs_frm_i,
    input  logic [FLEN-1:0]                     rs_rs1_i,
    input  logic [FLEN-1:0]                     rs_rs2_i,
    input  logic [FLEN-1:0]                     rs_rs3_i,
    input  rob_idx_t                            rs_rob_idx_i,
    input  logic [2:0]                          csr_frm_i,
    output logic [NUM_LANES-1:0]                lane_valid_o,
    input  logic [NUM_LANES-1:0]                lane_ready_i,
    output logic [EU_CTL_LEN-1:0]               lane_ctl_o,
    output logic [2:0]                          lane_rm_o,
    output logic [FLEN-1:0]                     lane_rs1_o,
    output logic [FLEN-1:0]                     lane_rs2_o,
    output logic [FLEN-1:0]                     lane_rs3_o,
    output rob_idx_t                            lane_rob_idx_o,
    input  logic [NUM_LANES-1:0]                lane_res_valid_i,
    output logic [NUM_LANES-1:0]                lane_res_ready_o,
    input  rob_idx_t     [NUM_LANES-1:0]        lane_res_rob_idx_i,
    input  logic         [NUM_LANES-1:0][FLEN-1:0] lane_res_result_i,
    input  logic         [NUM_LANES-1:0]        lane_res_except_raised_i,
    input  except_code_t [NUM_LANES-1:0]        lane_res_except_code_i,
    input  logic         [NUM_LANES-1:0][4:0]   lane_res_fflags_i,
    output logic                                res_valid_o,
    input  logic                                res_ready_i,
    output rob_idx_t                            res_rob_idx_o,
    output logic [FLEN-1:0]                     res_result_o,
    output logic                                res_except_raised_o,
    output except_code_t                        res_except_code_o,
    output logic [4:0]                          res_fflags_o,
    output logic                                busy_o
);
    localparam int CW   = $clog2(MAX_INFLIGHT + 1);
`ifdef FPU_RM_CHECK_EN
    localparam int NSRC = NUM_LANES + 1;
`else
    localparam int NSRC = NUM_LANES;
`endif
    localparam int DIW  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int OIW  = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [NUM_LANES-1:0][CW-1:0] r_inflight;
    logic [NUM_LANES-1:0]         r_buf_valid;
    fpu_res_t [NUM_LANES-1:0]     r_buf;
    logic [DIW-1:0]               r_rr_disp;
    logic [OIW-1:0]               r_rr_out;
    logic                         r_lock;
    logic [OIW-1:0]               r_lock_idx;

    logic [2:0]           w_rm;
    logic                 w_illegal;
    logic                 w_byp_free;
    logic [NUM_LANES-1:0] w_elig;
    logic [NUM_LANES-1:0] w_disp_gnt;
    logic [DIW-1:0]       w_disp_idx;
    logic                 w_disp_any;
    logic                 w_disp_fire;
    logic [NUM_LANES-1:0] w_cap;
    logic [NUM_LANES-1:0] w_drain;
    logic [NUM_LANES-1:0] w_idle;
    logic [NSRC-1:0]      w_src_valid;
    fpu_res_t [NSRC-1:0]  w_src;
    logic [OIW-1:0]       w_out_idx;
    logic                 w_out_any;
    logic [OIW-1:0]       w_win;
    logic                 w_out_fire;
    fpu_res_t             w_res;

    assign w_rm = (rs_frm_i == FPU_RM_DYN) ? csr_frm_i : rs_frm_i;

`ifdef FPU_RM_CHECK_EN
    logic     r_byp_valid;
    fpu_res_t r_byp;
    assign w_illegal  = rm_is_illegal(w_rm);
    assign w_byp_free = !r_byp_valid;
`else
    assign w_illegal  = 1'b0;
    assign w_byp_free = 1'b0;
`endif

    // Operation fields are broadcast to every lane unmodified
    assign lane_ctl_o     = rs_ctl_i;
    assign lane_rm_o      = w_rm;
    assign lane_rs1_o     = rs_rs1_i;
    assign lane_rs2_o     = rs_rs2_i;
    assign lane_rs3_o     = rs_rs3_i;
    assign lane_rob_idx_o = rs_rob_idx_i;

    // A lane is eligible when ready and below its in-flight limit
    always_comb begin
        w_elig = '0;
        w_idle = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            w_elig[l] = lane_ready_i[l] && (r_inflight[l] < CW'(MAX_INFLIGHT));
            w_idle[l] = (r_inflight[l] == '0);
        end
    end

    fpu_rr_picker #(.N(NUM_LANES), .IW(DIW)) u_disp_pick (
        .req_i (w_elig),
        .ptr_i (r_rr_disp),
        .gnt_o (w_disp_gnt),
        .idx_o (w_disp_idx),
        .any_o (w_disp_any)
    );

    // Accept an op when a lane (or, for illegal rm, the bypass slot) can take it
    always_comb begin
        if (rst_i || flush_i) begin
            rs_ready_o = 1'b0;
        end else if (w_illegal) begin
            rs_ready_o = w_byp_free;
        end else begin
            rs_ready_o = w_disp_any;
        end
    end

    assign w_disp_fire  = rs_valid_i && rs_ready_o && !w_illegal;
    assign lane_valid_o = w_disp_fire ? w_disp_gnt : '0;

    // Collect the result sources: lane buffers, then the bypass slot
    always_comb begin
        w_src_valid = '0;
        w_src       = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            w_src_valid[l] = r_buf_valid[l];
            w_src[l]       = r_buf[l];
        end
`ifdef FPU_RM_CHECK_EN
        w_src_valid[NUM_LANES] = r_byp_valid;
        w_src[NUM_LANES]       = r_byp;
`endif
    end

    fpu_rr_picker #(.N(NSRC), .IW(OIW)) u_out_pick (
        .req_i (w_src_valid),
        .ptr_i (r_rr_out),
        .gnt_o (),
        .idx_o (w_out_idx),
        .any_o (w_out_any)
    );

    assign w_win       = r_lock ? r_lock_idx : w_out_idx;
    assign res_valid_o = w_out_any;
    assign w_out_fire  = res_valid_o && res_ready_i;

    // AND-OR mux of the winning source onto the result bus
    always_comb begin
        w_res = '0;
        for (int s = 0; s < NSRC; s++) begin
            w_res = w_res | ({$bits(fpu_res_t){w_win == OIW'(s)}} & w_src[s]);
        end
    end

    assign res_rob_idx_o       = w_res.rob_idx;
    assign res_result_o        = w_res.result;
    assign res_except_raised_o = w_res.except_raised;
    assign res_except_code_o   = w_res.except_code;
    assign res_fflags_o        = w_res.fflags;

    // Lane result handshake: buffer free or draining; flush swallows results
    always_comb begin
        lane_res_ready_o = '0;
        w_drain          = '0;
        w_cap            = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            w_drain[l]          = w_out_fire && (w_win == OIW'(l));
            lane_res_ready_o[l] = !rst_i && (flush_i || !r_buf_valid[l] || w_drain[l]);
            w_cap[l]            = lane_res_valid_i[l] && lane_res_ready_o[l] && !flush_i;
        end
    end

    // Busy while anything is in flight or waiting to be returned
    always_comb begin
        busy_o = |w_src_valid;
        for (int l = 0; l < NUM_LANES; l++) begin
            busy_o = busy_o | (r_inflight[l] != '0);
        end
    end

    // Per-lane in-flight counters and one-entry result buffers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_inflight  <= '0;
            r_buf_valid <= '0;
            r_buf       <= '0;
        end else if (flush_i) begin
            r_inflight  <= '0;
            r_buf_valid <= '0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                case ({lane_valid_o[l], w_cap[l]})
                    2'b10:   r_inflight[l] <= r_inflight[l] + CW'(1);
                    2'b01:   r_inflight[l] <= r_inflight[l] - CW'(1);
                    default: r_inflight[l] <= r_inflight[l];
                endcase
                if (w_cap[l]) begin
                    r_buf_valid[l] <= 1'b1;
                    r_buf[l]       <= '{rob_idx:       lane_res_rob_idx_i[l],
                                        result:        lane_res_result_i[l],
                                        except_raised: lane_res_except_raised_i[l],
                                        except_code:   lane_res_except_code_i[l],
                                        fflags:        lane_res_fflags_i[l]};
                end else if (w_drain[l]) begin
                    r_buf_valid[l] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointers and output grant lock (pointers survive flush)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_disp  <= '0;
            r_rr_out   <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else begin
            if (w_disp_fire) begin
                r_rr_disp <= (w_disp_idx == DIW'(NUM_LANES - 1)) ? '0 : w_disp_idx + DIW'(1);
            end
            if (w_out_fire) begin
                r_rr_out <= (w_win == OIW'(NSRC - 1)) ? '0 : w_win + OIW'(1);
            end
            if (flush_i || w_out_fire) begin
                r_lock <= 1'b0;
            end else if (res_valid_o) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_win;
            end else begin
                r_lock <= 1'b0;
            end
        end
    end

`ifdef FPU_RM_CHECK_EN
    // Bypass slot: illegal-rm ops complete here with an exception
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_byp_valid <= 1'b0;
            r_byp       <= '0;
        end else if (flush_i) begin
            r_byp_valid <= 1'b0;
        end else if (rs_valid_i && rs_ready_o && w_illegal) begin
            r_byp_valid <= 1'b1;
            r_byp       <= '{rob_idx:       rs_rob_idx_i,
                             result:        '0,
                             except_raised: 1'b1,
                             except_code:   E_ILLEGAL_INSTRUCTION,
                             fflags:        5'd0};
        end else if (w_out_fire && (w_win == OIW'(NUM_LANES))) begin
            r_byp_valid <= 1'b0;
        end
    end
`endif

    fpu_lane_cluster_chk #(.N(NUM_LANES)) u_chk (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .cap_i  (w_cap),
        .idle_i (w_idle)
    );
endmodule

// File: tb/tb_fpu_lane_cluster.sv
// Directed bench for fpu_lane_cluster (NUM_LANES=2, MAX_INFLIGHT=2).
module tb_fpu_lane_cluster;
    import len5_pkg::*;

    logic                        clk_i = 1'b0;
    logic                        rst_i, flush_i;
    logic                        rs_valid_i, rs_ready_o;
    logic [3:0]                  rs_ctl_i;
    logic [2:0]                  rs_frm_i, csr_frm_i;
    logic [FLEN-1:0]             rs_rs1_i, rs_rs2_i, rs_rs3_i;
    rob_idx_t                    rs_rob_idx_i;
    logic [1:0]                  lane_valid_o, lane_ready_i;
    logic [3:0]                  lane_ctl_o;
    logic [2:0]                  lane_rm_o;
    logic [FLEN-1:0]             lane_rs1_o, lane_rs2_o, lane_rs3_o;
    rob_idx_t                    lane_rob_idx_o;
    logic [1:0]                  lane_res_valid_i, lane_res_ready_o;
    rob_idx_t     [1:0]          lane_res_rob_idx_i;
    logic         [1:0][FLEN-1:0] lane_res_result_i;
    logic [1:0]                  lane_res_except_raised_i;
    except_code_t [1:0]          lane_res_except_code_i;
    logic         [1:0][4:0]     lane_res_fflags_i;
    logic                        res_valid_o, res_ready_i;
    rob_idx_t                    res_rob_idx_o;
    logic [FLEN-1:0]             res_result_o;
    logic                        res_except_raised_o;
    except_code_t                res_except_code_o;
    logic [4:0]                  res_fflags_o;
    logic                        busy_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    fpu_lane_cluster #(.NUM_LANES(2), .MAX_INFLIGHT(2), .EU_CTL_LEN(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .rs_valid_i(rs_valid_i), .rs_ready_o(rs_ready_o), .rs_ctl_i(rs_ctl_i),
        .rs_frm_i(rs_frm_i), .rs_rs1_i(rs_rs1_i), .rs_rs2_i(rs_rs2_i), .rs_rs3_i(rs_rs3_i),
        .rs_rob_idx_i(rs_rob_idx_i), .csr_frm_i(csr_frm_i),
        .lane_valid_o(lane_valid_o), .lane_ready_i(lane_ready_i), .lane_ctl_o(lane_ctl_o),
        .lane_rm_o(lane_rm_o), .lane_rs1_o(lane_rs1_o), .lane_rs2_o(lane_rs2_o),
        .lane_rs3_o(lane_rs3_o), .lane_rob_idx_o(lane_rob_idx_o),
        .lane_res_valid_i(lane_res_valid_i), .lane_res_ready_o(lane_res_ready_o),
        .lane_res_rob_idx_i(lane_res_rob_idx_i), .lane_res_result_i(lane_res_result_i),
        .lane_res_except_raised_i(lane_res_except_raised_i),
        .lane_res_except_code_i(lane_res_except_code_i), .lane_res_fflags_i(lane_res_fflags_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_rob_idx_o(res_rob_idx_o),
        .res_result_o(res_result_o), .res_except_raised_o(res_except_raised_o),
        .res_except_code_o(res_except_code_o), .res_fflags_o(res_fflags_o), .busy_o(busy_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic op(input logic [3:0] rob, input logic [2:0] frm);
        rs_valid_i   = 1'b1;
        rs_rob_idx_i = rob;
        rs_frm_i     = frm;
        rs_ctl_i     = rob;
        rs_rs1_i     = {60'd0, rob};
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; rs_valid_i = 1'b0; rs_ctl_i = 4'd0;
        rs_frm_i = 3'b000; csr_frm_i = 3'b000; rs_rs1_i = '0; rs_rs2_i = '0; rs_rs3_i = '0;
        rs_rob_idx_i = '0; lane_ready_i = 2'b11; lane_res_valid_i = 2'b00;
        lane_res_rob_idx_i = '0; lane_res_result_i = '0; lane_res_except_raised_i = '0;
        lane_res_except_code_i = '0; lane_res_fflags_i = '0; res_ready_i = 1'b1;

        tick();
        #1 check("rst_rs_ready", rs_ready_o, 0);
        tick();
        rst_i = 1'b0;
        #1;
        check("rst_res_valid", res_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_lane_valid", lane_valid_o, 0);
        check("rst_rs_ready_idle", rs_ready_o, 1);
        check("rst_lane_res_ready", lane_res_ready_o, 2'b11);

        // Dispatch rotation plus rm resolution
        op(4'd0, 3'b001); #1;
        check("rot0_lane", lane_valid_o, 2'b01);
        check("rm_static", lane_rm_o, 3'b001);
        check("rot0_rob", lane_rob_idx_o, 4'd0);
        tick(); op(4'd1, 3'b111); csr_frm_i = 3'b010; #1;
        check("rot1_lane", lane_valid_o, 2'b10);
        check("rm_dynamic", lane_rm_o, 3'b010);
        tick(); op(4'd2, 3'b000); #1;
        check("rot2_lane", lane_valid_o, 2'b01);
        tick(); op(4'd3, 3'b000); #1;
        check("rot3_lane", lane_valid_o, 2'b10);
        check("rot3_ctl", lane_ctl_o, 4'd3);
        // Both lanes at the limit: rob4 stalls
        tick(); op(4'd4, 3'b000); #1;
        check("limit_rs_ready", rs_ready_o, 0);
        check("limit_lane_valid", lane_valid_o, 2'b00);
        check("limit_busy", busy_o, 1);
        // Lane 0 returns rob0; stall persists in this cycle
        lane_res_valid_i = 2'b01; lane_res_rob_idx_i[0] = 4'd0;
        lane_res_result_i[0] = 64'hA0; lane_res_fflags_i[0] = 5'h03; #1;
        check("cap0_ready", lane_res_ready_o[0], 1);
        check("cap0_still_stalled", rs_ready_o, 0);
        tick(); lane_res_valid_i = 2'b00; #1;
        check("ret0_valid", res_valid_o, 1);
        check("ret0_rob", res_rob_idx_o, 4'd0);
        check("ret0_result", res_result_o, 64'hA0);
        check("ret0_fflags", res_fflags_o, 5'h03);
        check("unstall_rs_ready", rs_ready_o, 1);
        check("unstall_lane", lane_valid_o, 2'b01);
        tick(); rs_valid_i = 1'b0; #1;
        check("drained_valid", res_valid_o, 0);

        // Backpressure: both lanes return together, output held while not ready
        res_ready_i = 1'b0;
        lane_res_valid_i = 2'b11;
        lane_res_rob_idx_i[0] = 4'd2; lane_res_result_i[0] = 64'hB2; lane_res_fflags_i[0] = 5'h00;
        lane_res_rob_idx_i[1] = 4'd1; lane_res_result_i[1] = 64'hC1; lane_res_fflags_i[1] = 5'h10;
        tick(); lane_res_valid_i = 2'b00; #1;
        check("bp_c1_valid", res_valid_o, 1);
        check("bp_c1_rob", res_rob_idx_o, 4'd1);
        check("bp_full_ready", lane_res_ready_o, 2'b00);
        tick(); #1;
        check("bp_c2_rob", res_rob_idx_o, 4'd1);
        check("bp_c2_result", res_result_o, 64'hC1);
        tick(); #1;
        check("bp_c3_rob", res_rob_idx_o, 4'd1);
        check("bp_c3_fflags", res_fflags_o, 5'h10);
        res_ready_i = 1'b1; #1;
        check("bp_drain_lane1_ready", lane_res_ready_o, 2'b10);
        tick(); #1;
        check("bp_next_valid", res_valid_o, 1);
        check("bp_next_rob", res_rob_idx_o, 4'd2);
        check("bp_next_result", res_result_o, 64'hB2);
        tick(); #1;
        check("bp_empty", res_valid_o, 0);
        check("bp_busy", busy_o, 1);

        // Refill to inflight {2,2}, buffer two results, then flush
        op(4'd5, 3'b000); #1;
        check("fl_rob5_lane", lane_valid_o, 2'b10);
        tick(); op(4'd6, 3'b000); #1;
        check("fl_rob6_lane", lane_valid_o, 2'b01);
        tick(); rs_valid_i = 1'b0; res_ready_i = 1'b0;
        lane_res_valid_i = 2'b11;
        lane_res_rob_idx_i[0] = 4'd4; lane_res_result_i[0] = 64'hD4;
        lane_res_rob_idx_i[1] = 4'd3; lane_res_result_i[1] = 64'hE3;
        tick(); lane_res_valid_i = 2'b00; #1;
        check("fl_pre_valid", res_valid_o, 1);
        check("fl_pre_rob", res_rob_idx_o, 4'd3);
        flush_i = 1'b1; op(4'd7, 3'b000); #1;
        check("fl_rs_ready", rs_ready_o, 0);
        check("fl_lane_valid", lane_valid_o, 2'b00);
        check("fl_lane_res_ready", lane_res_ready_o, 2'b11);
        tick(); flush_i = 1'b0; #1;
        check("fl_post_valid", res_valid_o, 0);
        check("fl_post_busy", busy_o, 0);
        check("fl_post_lane", lane_valid_o, 2'b10);
        check("fl_post_rob", lane_rob_idx_o, 4'd7);
        tick(); rs_valid_i = 1'b0; res_ready_i = 1'b1; #1;
        check("fl_post_busy2", busy_o, 1);

        // Reserved rounding mode
        op(4'd9, 3'b101); #1;
`ifdef FPU_RM_CHECK_EN
        check("ill_lane_valid", lane_valid_o, 2'b00);
        check("ill_rs_ready", rs_ready_o, 1);
        tick(); rs_valid_i = 1'b0; #1;
        check("ill_res_valid", res_valid_o, 1);
        check("ill_except", res_except_raised_o, 1);
        check("ill_code", res_except_code_o, 5'd2);
        check("ill_rob", res_rob_idx_o, 4'd9);
        check("ill_result", res_result_o, 64'd0);
        tick(); #1;
        check("ill_drained", res_valid_o, 0);
`else
        check("rm101_lane_valid", lane_valid_o, 2'b01);
        check("rm101_forwarded", lane_rm_o, 3'b101);
        tick(); rs_valid_i = 1'b0; #1;
        check("rm101_no_result", res_valid_o, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fpu_lane_cluster.md
# fpu_lane_cluster

Multi-lane floating-point dispatch/collect stage placed between the FPU reservation station and `NUM_LANES` independent FPU wrapper lanes. Resolves the rounding mode, rejects illegal rounding modes, steers each accepted operation to a free lane by round-robin, and tracks per-lane in-flight counts. Buffers lane results and returns them to the reservation station one per cycle, in completion order, tagged by ROB index.

## Interface
- `NUM_LANES`, 2: number of FPU lanes (≥1).
- `MAX_INFLIGHT`, 4: maximum operations outstanding per lane (≥1).
- `EU_CTL_LEN`, 4: FPU control field width.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. One clock; reset is synchronous and active-high.
- `flush_i` in 1: pipeline flush, synchronous. Also wired directly to every lane.
- `rs_valid_i`/`rs_ready_o` in/out 1: operation handshake from the reservation station.
- `rs_ctl_i` in EU_CTL_LEN: operation.
- `rs_frm_i` in 3: instruction rm field.
- `rs_rs1_i`/`rs_rs2_i`/`rs_rs3_i` in FLEN: operands.
- `rs_rob_idx_i` in rob_idx_t: destination tag.
- `csr_frm_i` in 3: fcsr.frm.
- `lane_valid_o` out NUM_LANES: one-hot dispatch strobe.
- `lane_ready_i` in NUM_LANES: lane can accept.
- `lane_ctl_o`, `lane_rm_o`, `lane_rs1_o`..`lane_rs3_o`, `lane_rob_idx_o` out: operation fields, broadcast to all lanes.
- `lane_res_valid_i`/`lane_res_ready_o` in/out NUM_LANES: result handshake per lane.
- `lane_res_rob_idx_i`, `lane_res_result_i` [FLEN], `lane_res_except_raised_i`, `lane_res_except_code_i`, `lane_res_fflags_i` [5] in, ×NUM_LANES: lane results.
- `res_valid_o`/`res_ready_i` out/in 1: result handshake to the reservation station.
- `res_rob_idx_o`, `res_result_o`, `res_except_raised_o`, `res_except_code_o`, `res_fflags_o` out: selected result.
- `busy_o` out 1: any in-flight op or buffered result.

## Operation
- Rounding mode: `rm = (rs_frm_i == 3'b111) ? csr_frm_i : rs_frm_i`. The mode is illegal if the resolved value is 101, 110 or 111.
- Eligible lane: `lane_ready_i[l]` && `inflight[l] < MAX_INFLIGHT`.
- Dispatch:
  - A rotating pointer picks the first eligible lane at or after `rr_disp`.
  - `rs_ready_o` = any eligible lane. Operands are passed through combinationally.
  - On a handshake: `inflight[sel]` +1 and `rr_disp` = sel+1 mod NUM_LANES.
- Illegal rm (with the macro defined):
  - No lane is strobed. The op is written into a one-entry bypass slot with `except_raised=1`, code `E_ILLEGAL_INSTRUCTION`, result 0, fflags 0.
  - `rs_ready_o` for such an op = bypass slot empty.
- Result capture:
  - Each lane has a one-entry result buffer. `lane_res_ready_o[l]` = buffer empty, or buffer drained this cycle.
  - On capture: `inflight[l]` −1.
  - Dispatch and capture on the same lane in the same cycle leave `inflight` unchanged.
  - A capture while `inflight[l]==0` is an assertion failure.
- Output:
  - The sources are the NUM_LANES buffers plus the bypass slot (index NUM_LANES). A round-robin pointer `rr_out` selects among them.
  - Once `res_valid_o` rises, the grant is locked and the outputs are held stable until `res_ready_i`. After the handshake, `rr_out` = winner+1.
- Flush:
  - Clears all buffers, the bypass slot and every `inflight`.
  - Forces `rs_ready_o=0` and `lane_valid_o=0` in that cycle.
  - Lane results presented during flush are accepted and discarded.
  - The RR pointers are kept.
- Reset: all buffers empty, `inflight=0`, `rr_disp=rr_out=0`. All outputs are 0 except the pass-through data buses.

## Timing
- Dispatch: 0 cycles, issue to lane.
- Lane result to `res_valid_o`: 1 cycle (registered buffer).
- Illegal-rm op to `res_valid_o`: 1 cycle.
- Throughput: one dispatch and one return per cycle.
- A full buffer can be drained and refilled in the same cycle.
- `res_*` obeys valid/ready: valid never drops without a handshake, except on flush or reset.
- `busy_o` is registered state OR'd combinationally: 0 after reset and after flush.

## Configuration
- `FPU_RM_CHECK_EN` defined: illegal-rm detection and the bypass slot are built; the output arbiter has NUM_LANES+1 sources.
- `FPU_RM_CHECK_EN` undefined:
  - No check is made. The resolved rm is forwarded to the lane unmodified.
  - The arbiter has NUM_LANES sources, and the bypass logic is absent.

## Structure
- Shared in `expipe_pkg`: `fpu_res_t`, a struct {rob_idx, result, except_raised, except_code, fflags} used for buffers and the bypass slot.
- Shared in `len5_pkg` (already present): the `FPU_RM_DYN=3'b111` constant and `E_ILLEGAL_INSTRUCTION`.
- Sub-module `fpu_rr_picker #(N)`: request vector + pointer → one-hot grant plus index. Instantiated twice, once for dispatch and once for output.

## Test plan
- **Dispatch rotation.** NUM_LANES=2, all lanes ready, 4 back-to-back ops with rob 0..3 → `lane_valid_o` = 01,10,01,10; `inflight` = {2,2}.
- **Dynamic rm.** `rs_frm_i=111`, `csr_frm_i=010` → `lane_rm_o=010`. `rs_frm_i=001` → `lane_rm_o=001`.
- **Illegal rm, macro on.** `rs_frm_i=101` → no lane strobe. Next cycle `res_valid_o=1`, `except_raised=1`, code=2, `rob_idx` echoed.
- **Backpressure and lock.** Lane 0 and lane 1 results arrive together, `res_ready_i=0` for 3 cycles → lane 0 result held stable for 3 cycles. After release, lane 1 result follows in the next cycle.
- **Inflight limit.** MAX_INFLIGHT=2, lane 1 not ready, 3 ops issued with no results returned → third op stalls (`rs_ready_o=0`) until lane 0 returns a result.
- **Flush.** Flush with 2 buffered results and `inflight={1,1}` → next cycle `res_valid_o=0`, `busy_o=0`, and a new op dispatches normally.
